operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 8, datapath and register width.
REQ-002 Parameter ADDR_W, default 3, register-address width (8 registers).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  decoded instruction present.
REQ-007 in_ready  output  1  block accepts instruction this cycle.
REQ-008 in_op  input  4  opcode, passed through.
REQ-009 in_rs, in_rt, in_rd  input  ADDR_W each  source 1, source 2, destination register.
REQ-010 in_imm  input  DATA_W  immediate, passed through.
REQ-011 reg_read_1, reg_read_2  output  ADDR_W each  register-file read addresses.
REQ-012 rf_data_1, rf_data_2  input  DATA_W each  register-file read data, combinational from reg_read_1/2, valid in the same cycle.
REQ-013 wb_en, wb_addr, wb_data  input  1/ADDR_W/DATA_W  register-file write port, observed for forwarding.
REQ-014 out_valid  output  1  operands valid.
REQ-015 out_ready  input  1  downstream ALU accepts.
REQ-016 out_op, out_rd, out_imm  output  4/ADDR_W/DATA_W  registered pass-through fields.
REQ-017 out_a, out_b  output  DATA_W each  operand values of rs and rt.

Function
REQ-018 States SHALL be IDLE, FETCH and HOLD.
REQ-019 in_ready SHALL be 1 in IDLE, 0 in FETCH, and equal to out_ready in HOLD.
REQ-020 Accept = in_valid & in_ready; on accept, in_op/rs/rt/rd/imm SHALL be latched and the state SHALL go to FETCH.
REQ-021 reg_read_1/reg_read_2 SHALL equal the latched rs/rt in every state.
REQ-022 At the FETCH clock edge, out_a SHALL load wb_data if wb_en & wb_addr==rs & rs!=0, else rf_data_1; out_b likewise for rt with rf_data_2.
REQ-023 Any operand with address 0 SHALL load 0 regardless of rf_data or wb.
REQ-024 FETCH SHALL always go to HOLD; out_valid SHALL be 1 exactly in HOLD.
REQ-025 Latency: instruction accepted at edge N SHALL show out_valid=1 after edge N+1.
REQ-026 In HOLD with out_ready=0, outputs SHALL stay stable, except per REQ-027.
REQ-027 In HOLD, a write with wb_en=1 and nonzero wb_addr equal to the held rs (rt) SHALL update out_a (out_b) with wb_data at that edge; both SHALL update if rs==rt.
REQ-028 HOLD with out_ready=1 and in_valid=1: the new instruction SHALL be accepted and the state SHALL go to FETCH (out_valid drops for one cycle).
REQ-029 HOLD with out_ready=1 and in_valid=0: the state SHALL go to IDLE.
REQ-030 wb_en=1 with wb_addr=0 SHALL never affect outputs.
REQ-031 Throughput SHALL be at most one instruction every 2 cycles.

Reset
REQ-032 While rst=1 at a clock edge: state SHALL become IDLE; out_valid, out_op, out_rd, out_imm, out_a, out_b and the latched fields SHALL become 0, so reg_read_1/2=0.
REQ-033 Reset SHALL take priority over accept, FETCH capture and forwarding, including an instruction in FETCH or HOLD, which SHALL be discarded.
REQ-034 After reset deassertion, in_ready SHALL be 1 in the first cycle.

Verification
REQ-035 Reset, then accept rs=2, rt=3 with the register file holding R2=0x11 and R3=0x22 -> out_valid=1 two edges later, out_a=0x11, out_b=0x22.
REQ-036 Accept rs=4 while wb_en=1, wb_addr=4, wb_data=0x5A coincides with the FETCH edge and R4 holds 0x00 -> out_a=0x5A.
REQ-037 Accept rs=0, rt=0 with rf_data forced to 0xFF and wb_en=1, wb_addr=0, wb_data=0x77 -> out_a=out_b=0x00.
REQ-038 Hold out_ready=0 for 3 cycles in HOLD while writing 0x3C to the held rt=5 -> out_b changes to 0x3C and all other outputs stay stable.
REQ-039 Back-to-back: in_valid held 1 with out_ready=1 -> one accept every 2 cycles and out_valid toggles 1,0,1,0.
REQ-040 Assert rst during HOLD -> next cycle out_valid=0, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches a decoded instruction, reads both source registers with
// write-back forwarding, and holds the operand bundle until the ALU takes it.
module operand_fetch #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] reg_read_1,
    output logic [ADDR_W-1:0] reg_read_2,
    input  logic [DATA_W-1:0] rf_data_1,
    input  logic [DATA_W-1:0] rf_data_2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a HOLD bundle stays put until it is taken.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        lat_op;
    logic [ADDR_W-1:0] lat_rs, lat_rt, lat_rd;
    logic [DATA_W-1:0] lat_imm;

    logic              accept;
    logic [DATA_W-1:0] fetch_a, fetch_b;
    logic              hit_a, hit_b;

    always_comb begin
        in_ready  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = FETCH;
            end
            FETCH: state_nxt = HOLD;
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? FETCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Register 0 is hard-wired zero, so it never reads data or takes a forwarded write.
    always_comb begin
        fetch_a = '0;
        fetch_b = '0;
        if (lat_rs != '0) fetch_a = (wb_en && wb_addr == lat_rs) ? wb_data : rf_data_1;
        if (lat_rt != '0) fetch_b = (wb_en && wb_addr == lat_rt) ? wb_data : rf_data_2;
    end

    assign hit_a = wb_en && (wb_addr != '0) && (wb_addr == lat_rs);
    assign hit_b = wb_en && (wb_addr != '0) && (wb_addr == lat_rt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_op  <= '0;
            lat_rs  <= '0;
            lat_rt  <= '0;
            lat_rd  <= '0;
            lat_imm <= '0;
            out_op  <= '0;
            out_rd  <= '0;
            out_imm <= '0;
            out_a   <= '0;
            out_b   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_op  <= in_op;
                lat_rs  <= in_rs;
                lat_rt  <= in_rt;
                lat_rd  <= in_rd;
                lat_imm <= in_imm;
            end
            if (state == FETCH) begin
                out_op  <= lat_op;
                out_rd  <= lat_rd;
                out_imm <= lat_imm;
                out_a   <= fetch_a;
                out_b   <= fetch_b;
            end else if (state == HOLD) begin
                // Keep held operands coherent with writes that land while we wait.
                if (hit_a) out_a <= wb_data;
                if (hit_b) out_b <= wb_data;
            end
        end
    end

    assign out_valid  = (state == HOLD);
    assign reg_read_1 = lat_rs;
    assign reg_read_2 = lat_rt;
    assign dbg_state  = state;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: register-file model, driver tasks and a
// scoreboard queue of expected operand bundles popped on each output handshake.
module tb_operand_fetch;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OUT_W  = 4 + ADDR_W + 3 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_rs, in_rt, in_rd;
  logic [DATA_W-1:0] in_imm;
  logic [ADDR_W-1:0] reg_read_1, reg_read_2;
  logic [DATA_W-1:0] rf_data_1, rf_data_2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0] out_imm, out_a, out_b;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] tb_rf [8];
  logic              force_ff;
  logic [OUT_W-1:0]  exp_q [$];
  logic [OUT_W-1:0]  mon_exp;
  int                checks = 0;
  int                failures = 0;

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .reg_read_1(reg_read_1), .reg_read_2(reg_read_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_imm(out_imm),
    .out_a(out_a), .out_b(out_b),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // register file model: reloads known contents on reset, absorbs write-back traffic
  always @(posedge clk) begin
    if (rst) begin
      tb_rf[0] <= 8'hAA; tb_rf[1] <= 8'h01; tb_rf[2] <= 8'h11; tb_rf[3] <= 8'h22;
      tb_rf[4] <= 8'h00; tb_rf[5] <= 8'h55; tb_rf[6] <= 8'h66; tb_rf[7] <= 8'h77;
    end else if (wb_en && wb_addr != 0) begin
      tb_rf[wb_addr] <= wb_data;
    end
  end

  assign rf_data_1 = force_ff ? 8'hFF : tb_rf[reg_read_1];
  assign rf_data_2 = force_ff ? 8'hFF : tb_rf[reg_read_2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] out_bundle();
    return {out_op, out_rd, out_imm, out_a, out_b};
  endfunction

  function automatic logic [DATA_W-1:0] rf_read(input logic [ADDR_W-1:0] a);
    return force_ff ? 8'hFF : tb_rf[a];
  endfunction

  // scoreboard: compare whatever the DUT hands over against the oldest expectation
  initial forever begin
    @(negedge clk);
    #2;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", 32'(out_bundle()), 32'(mon_exp));
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
  endtask

  // One instruction: accept, FETCH with an optional coincident write, hold_n stalled
  // HOLD cycles with writes (fixed or random), then release to the scoreboard.
  task automatic send(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic [7:0] imm,
                      input logic f_en, input logic [2:0] f_addr, input logic [7:0] f_data,
                      input int hold_n, input logic h_fixed,
                      input logic [2:0] h_addr, input logic [7:0] h_data);
    logic [7:0] ea, eb;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("fetch_valid", 32'(out_valid), 32'd0);
    check("fetch_ready", 32'(in_ready), 32'd0);
    check("read_addr", 32'({reg_read_1, reg_read_2}), 32'({rs, rt}));
    wb_en = f_en; wb_addr = f_addr; wb_data = f_data;
    ea = (rs == 0) ? 8'h00 : (f_en && f_addr == rs) ? f_data : rf_read(rs);
    eb = (rt == 0) ? 8'h00 : (f_en && f_addr == rt) ? f_data : rf_read(rt);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= hold_n; k++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_out", 32'(out_bundle()), 32'({op, rd, imm, ea, eb}));
      if (k < hold_n) begin
        check("hold_ready", 32'(in_ready), 32'd0);
        if (h_fixed) begin
          wb_en = 1'b1; wb_addr = h_addr; wb_data = h_data;
        end else begin
          wb_en = 1'($urandom_range(0, 1));
          wb_addr = 3'($urandom_range(0, 7));
          wb_data = 8'($urandom_range(0, 255));
        end
        if (wb_en && wb_addr != 0) begin
          if (wb_addr == rs) ea = wb_data;
          if (wb_addr == rt) eb = wb_data;
        end
        @(posedge clk);
        @(negedge clk);
      end else begin
        wb_en = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({op, rd, imm, ea, eb});
      end
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // in_valid and out_ready held high: accept every second cycle, out_valid toggling
  task automatic back_to_back();
    int n;
    n = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    in_op = 4'(n); in_rs = 3'(n + 1); in_rt = 3'(n + 2); in_rd = 3'(n); in_imm = 8'(n * 16);
    exp_q.push_back({4'(n), 3'(n), 8'(n * 16), rf_read(3'(n + 1)), rf_read(3'(n + 2))});
    n++;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'(c % 2 == 0));
      check("b2b_ready", 32'(in_ready), 32'(c % 2 == 0));
      if (c % 2 == 1) begin
        if (c < 7) begin
          in_op = 4'(n); in_rs = 3'(n + 1); in_rt = 3'(n + 2); in_rd = 3'(n);
          in_imm = 8'(n * 16);
          exp_q.push_back({4'(n), 3'(n), 8'(n * 16), rf_read(3'(n + 1)), rf_read(3'(n + 2))});
          n++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    force_ff = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out_bundle()), 32'd0);
    check("rst_read", 32'({reg_read_1, reg_read_2}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // basic read of R2/R3
    send(4'h3, 3'd2, 3'd3, 3'd1, 8'h9C, 1'b0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 8'h00);
    // forward a write coinciding with the FETCH edge
    send(4'h5, 3'd4, 3'd2, 3'd6, 8'h42, 1'b1, 3'd4, 8'h5A, 0, 1'b0, 3'd0, 8'h00);
    // register 0 ignores both read data and forwarding
    force_ff = 1'b1;
    send(4'h7, 3'd0, 3'd0, 3'd7, 8'h01, 1'b1, 3'd0, 8'h77, 1, 1'b1, 3'd0, 8'h99);
    force_ff = 1'b0;
    // stalled HOLD picks up writes to the held rt only
    send(4'hA, 3'd2, 3'd5, 3'd3, 8'hE1, 1'b0, 3'd0, 8'h00, 3, 1'b1, 3'd5, 8'h3C);
    // rs == rt: both operands follow the write
    send(4'hB, 3'd6, 3'd6, 3'd2, 8'h10, 1'b0, 3'd0, 8'h00, 2, 1'b1, 3'd6, 8'hC3);

    back_to_back();

    for (int i = 0; i < 10; i++) begin
      send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), 1'b0, 3'd0, 8'h00);
    end

    // reset while an instruction sits in HOLD discards it
    in_valid = 1'b1; in_op = 4'hF; in_rs = 3'd1; in_rt = 3'd7; in_rd = 3'd5; in_imm = 8'h3E;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_hold", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_out", 32'(out_bundle()), 32'd0);
    check("hold_rst_read", 32'({reg_read_1, reg_read_2}), 32'd0);
    check("hold_rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rerst_ready", 32'(in_ready), 32'd1);
    send(4'h2, 3'd3, 3'd1, 3'd4, 8'h77, 1'b0, 3'd0, 8'h00, 1, 1'b0, 3'd0, 8'h00);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
